pointer_unit: RTL and testbench
===============================

Name: pointer_unit

Overview:
- Holds the CPU's two 16-bit memory pointers, the instruction pointer (IP) and the data pointer (DP).
- Sits directly downstream of control_unit and consumes its pointer-control strobes: increment IP, swap IP/DP, byte-write DP from DI, select the address source, and drive DP bytes onto the ALU B input.
- Drives the external address bus.

Parameters:
- ADDR_WIDTH, 16, pointer and address-bus width; must be 16 (two bytes).
- RESET_VECTOR, 16'h0000, IP value after reset.
- DP_RESET, 16'h0000, DP value after reset.

Ports:
- clk  input  1  clock; all state updates on posedge.
- n_rst  input  1  reset, synchronous, active-low.
- n_mem_rdy  input  1  0 = memory ready; 1 = stall, which freezes all state.
- inc_ip  input  1  increment IP this cycle.
- swap_p  input  1  single-cycle request to exchange IP and DP.
- addr_dp  input  1  0 = addr driven from IP, 1 = addr driven from DP.
- n_we_pl  input  1  write di into DP[7:0], active low.
- n_we_ph  input  1  write di into DP[15:8], active low.
- di  input  8  internal data bus.
- n_oe_pl_alu  input  1  drive DP[7:0] onto alu_b, active low.
- n_oe_ph_alu  input  1  drive DP[15:8] onto alu_b, active low.
- addr  output  16  memory address.
- alu_b  output  8  ALU B operand contribution.
- p_selector  output  1  current physical-register mapping (0: reg0 = IP).
- ip_wrap  output  1  sticky flag: IP has wrapped from 16'hFFFF to 16'h0000.

Behaviour:
- Storage:
  - Two physical registers, reg0 and reg1, plus the selector bit sel.
  - IP = sel ? reg1 : reg0.
  - DP = sel ? reg0 : reg1.
- Reset: synchronous active-low. On a posedge with n_rst=0:
  - reg0 = RESET_VECTOR, reg1 = DP_RESET, sel = 0, ip_wrap = 0.
  - Reset overrides stall and every strobe.
  - Reset asserted mid-operation discards any pending strobe.
- Stall: on a posedge with n_mem_rdy=1 and n_rst=1, reg0, reg1, sel and ip_wrap hold, and all strobes are ignored. Combinational outputs still track the inputs.
- Normal cycle (n_rst=1, n_mem_rdy=0). Every operation is evaluated against the pre-edge IP/DP mapping, then sel is updated.
  - inc_ip=1: IP register <= IP + 1, modulo 2^16.
    - 16'hFFFF -> 16'h0000 sets ip_wrap = 1.
    - ip_wrap stays set until reset.
  - n_we_pl=0: DP register[7:0] <= di.
  - n_we_ph=0: DP register[15:8] <= di.
  - Both write strobes low: both bytes take di.
  - swap_p=1: sel <= ~sel.
  - inc_ip with a DP write: they target different registers, so both apply.
  - inc_ip with swap_p: the old IP is incremented and then becomes DP. The new DP therefore holds the return address old_IP+1, and the new IP holds old_DP.
  - DP write with swap_p: the write lands in the old DP, which becomes the new IP. This allows "load target, jump" in one cycle.
- Combinational outputs:
  - addr = addr_dp ? DP : IP, with no register.
  - alu_b = DP[7:0] when n_oe_pl_alu=0.
  - Otherwise alu_b = DP[15:8] when n_oe_ph_alu=0.
  - Otherwise alu_b = 8'h00. This value is the zero operand.
  - Both oe strobes low: the low byte wins (defined priority).
  - p_selector = sel.
- Latency:
  - Pointer updates are visible on addr/alu_b immediately after the posedge that applies them.
  - No read-before-write bypass: during the cycle in which a write is requested, alu_b shows the pre-write value.

Decomposition:
- Package cpu_pkg:
  - ADDR_WIDTH and DATA_WIDTH=8 constants.
  - RESET_VECTOR default.
  - Localparam ALU_B_ZERO=8'h00.
- Sub-module pointer_reg, instantiated twice (reg0, reg1):
  - 16-bit register with synchronous active-low reset value parameter.
  - Enable.
  - Independent low/high byte write from an 8-bit input.
  - Increment with carry-out; carry-out feeds ip_wrap.
- pointer_unit contains:
  - The sel flop and the ip_wrap flop.
  - Per-register steering: which physical register receives the increment and which receives the byte writes, decided from sel.
  - The addr/alu_b muxes.

Test Plan:
- Reset then increment:
  - Stimulus: n_rst=0 for 1 edge, then inc_ip=1 for 3 edges, addr_dp=0.
  - Required: addr reads 0000, 0001, 0002, 0003; p_selector=0; ip_wrap=0.
- DP byte load and read-back:
  - Stimulus: n_we_pl=0 with di=8'h34, then n_we_ph=0 with di=8'h12, then addr_dp=1 with n_oe_ph_alu=0.
  - Required: addr=16'h1234, alu_b=8'h12; with n_oe_pl_alu=0 also low, alu_b=8'h34.
- Jump with increment:
  - Stimulus: IP=16'h0010, DP=16'h8000; one edge with inc_ip=1 and swap_p=1.
  - Required: IP=16'h8000, DP=16'h0011, p_selector=1.
  - Second swap: IP=16'h0011, DP=16'h8000, p_selector=0.
- Wrap:
  - Stimulus: IP loaded to 16'hFFFF via DP write plus swap, then inc_ip=1.
  - Required: IP=16'h0000 and ip_wrap=1; ip_wrap stays 1 after further increments; n_rst=0 clears it.
- Stall:
  - Stimulus: n_mem_rdy=1 with inc_ip=1, swap_p=1, n_we_pl=0 for 4 edges.
  - Required: IP, DP and p_selector unchanged; releasing the stall for one edge applies exactly one update.
- Reset mid-operation:
  - Stimulus: reset asserted in the same cycle as swap_p=1, n_we_ph=0, inc_ip=1, n_mem_rdy=1.
  - Required: after the edge, IP=RESET_VECTOR, DP=DP_RESET, p_selector=0, alu_b=8'h00 with both oe strobes high.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared widths, reset values and constants for the CPU datapath blocks.
// No logic. Constants only.
// Not applicable: this file carries no handshake.
package cpu_pkg;

    localparam int ADDR_WIDTH = 16;
    localparam int DATA_WIDTH = 8;

    localparam logic [ADDR_WIDTH-1:0] RESET_VECTOR = 16'h0000;
    localparam logic [ADDR_WIDTH-1:0] DP_RESET     = 16'h0000;

    // Value driven onto the ALU B operand when no pointer byte is selected.
    localparam logic [DATA_WIDTH-1:0] ALU_B_ZERO = 8'h00;

endpackage

// File: rtl/pointer_unit_if.sv
// Bundles the control strobes and outputs between control_unit and pointer_unit.
// No latency. Wires only.
// n_mem_rdy=1 is the stall; it travels with the strobes it qualifies.
interface pointer_unit_if;
    import cpu_pkg::*;

    logic                  n_mem_rdy;
    logic                  inc_ip;
    logic                  swap_p;
    logic                  addr_dp;
    logic                  n_we_pl;
    logic                  n_we_ph;
    logic [DATA_WIDTH-1:0] di;
    logic                  n_oe_pl_alu;
    logic                  n_oe_ph_alu;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] alu_b;
    logic                  p_selector;
    logic                  ip_wrap;

    // Control side: drives the strobes and observes the pointer outputs.
    modport master (
        output n_mem_rdy, inc_ip, swap_p, addr_dp, n_we_pl, n_we_ph, di,
               n_oe_pl_alu, n_oe_ph_alu,
        input  addr, alu_b, p_selector, ip_wrap
    );

    // Pointer side: consumes the strobes and drives the outputs.
    modport slave (
        input  n_mem_rdy, inc_ip, swap_p, addr_dp, n_we_pl, n_we_ph, di,
               n_oe_pl_alu, n_oe_ph_alu,
        output addr, alu_b, p_selector, ip_wrap
    );

endinterface

// File: rtl/pointer_reg.sv
// One 16-bit physical pointer register with increment and per-byte writes.
// Updates on the posedge; carry-out is combinational from the current value.
// i_en low holds the register and ignores increment and writes.
module pointer_reg
    import cpu_pkg::*;
#(
    parameter logic [ADDR_WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  i_en,
    input  logic                  i_inc,
    input  logic                  i_we_lo,
    input  logic                  i_we_hi,
    input  logic [DATA_WIDTH-1:0] i_di,
    output logic [ADDR_WIDTH-1:0] o_q,
    output logic                  o_carry
);

    logic [ADDR_WIDTH-1:0] r_q;
    logic [ADDR_WIDTH:0]   w_sum;
    logic [ADDR_WIDTH-1:0] w_next;

    assign w_sum = {1'b0, r_q} + {{ADDR_WIDTH{1'b0}}, 1'b1};

    // Next value: optional increment, then byte writes overlay it.
    always_comb begin
        w_next = i_inc ? w_sum[ADDR_WIDTH-1:0] : r_q;
        if (i_we_lo) w_next[DATA_WIDTH-1:0]          = i_di;
        if (i_we_hi) w_next[ADDR_WIDTH-1:DATA_WIDTH] = i_di;
    end

    // Register with synchronous reset and stall-hold enable.
    always_ff @(posedge clk) begin
        if (!n_rst)    r_q <= RESET_VAL;
        else if (i_en) r_q <= w_next;
    end

    assign o_q     = r_q;
    assign o_carry = i_inc & w_sum[ADDR_WIDTH];

endmodule

// File: rtl/pointer_unit.sv
// Holds IP and DP as two physical registers plus a mapping bit; drives addr and alu_b.
// State changes on the posedge; addr/alu_b are combinational from the current state.
// n_mem_rdy=1 freezes all state and discards strobes for that cycle.
module pointer_unit
    import cpu_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = cpu_pkg::ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = cpu_pkg::RESET_VECTOR,
    parameter logic [ADDR_WIDTH-1:0] DP_RESET     = cpu_pkg::DP_RESET
) (
    input logic           clk,
    input logic           n_rst,
    pointer_unit_if.slave bus
);

    // ADDR_WIDTH is fixed at two bytes: the byte-write and alu_b paths assume it.

    logic                  r_sel;
    logic                  r_ip_wrap;
    logic                  w_en;
    logic                  w_we_lo;
    logic                  w_we_hi;
    logic [ADDR_WIDTH-1:0] w_q0;
    logic [ADDR_WIDTH-1:0] w_q1;
    logic                  w_c0;
    logic                  w_c1;
    logic [ADDR_WIDTH-1:0] w_ip;
    logic [ADDR_WIDTH-1:0] w_dp;

    assign w_en    = ~bus.n_mem_rdy;
    assign w_we_lo = ~bus.n_we_pl;
    assign w_we_hi = ~bus.n_we_ph;

    // Steering uses the pre-edge mapping: sel=0 means reg0 is IP, reg1 is DP.
    // Swap only flips sel, so increment/write land in the old roles.
    pointer_reg #(.RESET_VAL(RESET_VECTOR)) u_reg0 (
        .clk     (clk),
        .n_rst   (n_rst),
        .i_en    (w_en),
        .i_inc   (bus.inc_ip & ~r_sel),
        .i_we_lo (w_we_lo & r_sel),
        .i_we_hi (w_we_hi & r_sel),
        .i_di    (bus.di),
        .o_q     (w_q0),
        .o_carry (w_c0)
    );

    pointer_reg #(.RESET_VAL(DP_RESET)) u_reg1 (
        .clk     (clk),
        .n_rst   (n_rst),
        .i_en    (w_en),
        .i_inc   (bus.inc_ip & r_sel),
        .i_we_lo (w_we_lo & ~r_sel),
        .i_we_hi (w_we_hi & ~r_sel),
        .i_di    (bus.di),
        .o_q     (w_q1),
        .o_carry (w_c1)
    );

    assign w_ip = r_sel ? w_q1 : w_q0;
    assign w_dp = r_sel ? w_q0 : w_q1;

    // Mapping bit: a swap exchanges IP/DP by relabelling, not by copying.
    always_ff @(posedge clk) begin
        if (!n_rst)                   r_sel <= 1'b0;
        else if (w_en && bus.swap_p)  r_sel <= ~r_sel;
    end

    // Sticky wrap flag: only the IP register is ever incremented, so either carry means IP wrapped.
    always_ff @(posedge clk) begin
        if (!n_rst)                  r_ip_wrap <= 1'b0;
        else if (w_en && (w_c0 | w_c1)) r_ip_wrap <= 1'b1;
    end

    // ALU B operand: low byte has priority over high byte, else the zero operand.
    always_comb begin
        bus.alu_b = ALU_B_ZERO;
        if (!bus.n_oe_pl_alu)      bus.alu_b = w_dp[DATA_WIDTH-1:0];
        else if (!bus.n_oe_ph_alu) bus.alu_b = w_dp[ADDR_WIDTH-1:DATA_WIDTH];
    end

    assign bus.addr       = bus.addr_dp ? w_dp : w_ip;
    assign bus.p_selector = r_sel;
    assign bus.ip_wrap    = r_ip_wrap;

endmodule

// File: tb/tb_pointer_unit.sv
// Directed bench for pointer_unit: a vector table applied edge by edge,
// plus hand sequences for mid-cycle behaviour (pre-write alu_b, stall tracking).
module tb_pointer_unit;
    import cpu_pkg::*;

    logic clk;
    logic n_rst;
    int   checks;
    int   errors;

    pointer_unit_if pu_if ();

    pointer_unit dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (pu_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        inc;
        logic        swp;
        logic        adp;
        logic        wpl;
        logic        wph;
        logic [7:0]  di;
        logic        opl;
        logic        oph;
        logic [15:0] e_addr;
        logic [7:0]  e_alu;
        logic        e_sel;
        logic        e_wrap;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, rdy, inc, swp, adp, wpl, wph,
                                input logic [7:0] d, input logic opl, oph,
                                input logic [15:0] ea, input logic [7:0] eb,
                                input logic es, ew);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.inc = inc; v.swp = swp; v.adp = adp;
        v.wpl = wpl; v.wph = wph; v.di = d; v.opl = opl; v.oph = oph;
        v.e_addr = ea; v.e_alu = eb; v.e_sel = es; v.e_wrap = ew;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        n_rst             = v.rst;
        pu_if.n_mem_rdy   = v.rdy;
        pu_if.inc_ip      = v.inc;
        pu_if.swap_p      = v.swp;
        pu_if.addr_dp     = v.adp;
        pu_if.n_we_pl     = v.wpl;
        pu_if.n_we_ph     = v.wph;
        pu_if.di          = v.di;
        pu_if.n_oe_pl_alu = v.opl;
        pu_if.n_oe_ph_alu = v.oph;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        drive(mk(0,0,0,0,0,1,1,8'h00,1,1, 16'h0000,8'h00,0,0));

        // Reset then increment
        vecs.push_back(mk(0,0,0,0,0,1,1,8'h00,1,1, 16'h0000,8'h00,0,0));
        vecs.push_back(mk(1,0,1,0,0,1,1,8'h00,1,1, 16'h0001,8'h00,0,0));
        vecs.push_back(mk(1,0,1,0,0,1,1,8'h00,1,1, 16'h0002,8'h00,0,0));
        vecs.push_back(mk(1,0,1,0,0,1,1,8'h00,1,1, 16'h0003,8'h00,0,0));
        // DP byte load and read-back
        vecs.push_back(mk(1,0,0,0,0,0,1,8'h34,1,1, 16'h0003,8'h00,0,0));
        vecs.push_back(mk(1,0,0,0,0,1,0,8'h12,1,1, 16'h0003,8'h00,0,0));
        vecs.push_back(mk(1,0,0,0,1,1,1,8'h00,1,0, 16'h1234,8'h12,0,0));
        vecs.push_back(mk(1,0,0,0,1,1,1,8'h00,0,0, 16'h1234,8'h34,0,0));
        // Jump with increment: IP=0010 via 16 increments, DP=8000
        vecs.push_back(mk(0,0,0,0,0,1,1,8'h00,1,1, 16'h0000,8'h00,0,0));
        for (int k = 1; k <= 16; k++)
            vecs.push_back(mk(1,0,1,0,0,1,1,8'h00,1,1, 16'(k),8'h00,0,0));
        vecs.push_back(mk(1,0,0,0,1,1,0,8'h80,1,1, 16'h8000,8'h00,0,0));
        vecs.push_back(mk(1,0,0,0,1,0,1,8'h00,1,1, 16'h8000,8'h00,0,0));
        vecs.push_back(mk(1,0,1,1,0,1,1,8'h00,0,1, 16'h8000,8'h11,1,0));
        vecs.push_back(mk(1,0,0,0,1,1,1,8'h00,1,1, 16'h0011,8'h00,1,0));
        vecs.push_back(mk(1,0,0,1,0,1,1,8'h00,1,1, 16'h0011,8'h00,0,0));
        vecs.push_back(mk(1,0,0,0,1,1,1,8'h00,1,0, 16'h8000,8'h80,0,0));
        // Wrap: load FFFF into DP and swap in the same cycle, then increment
        vecs.push_back(mk(1,0,0,1,0,0,0,8'hFF,1,1, 16'hFFFF,8'h00,1,0));
        vecs.push_back(mk(1,0,1,0,0,1,1,8'h00,0,1, 16'h0000,8'h11,1,1));
        vecs.push_back(mk(1,0,1,0,0,1,1,8'h00,1,1, 16'h0001,8'h00,1,1));
        vecs.push_back(mk(1,0,1,0,0,1,1,8'h00,1,1, 16'h0002,8'h00,1,1));
        vecs.push_back(mk(0,0,0,0,0,1,1,8'h00,1,1, 16'h0000,8'h00,0,0));
        // Stall: four frozen edges, then exactly one update
        vecs.push_back(mk(1,0,1,0,0,1,1,8'h00,1,1, 16'h0001,8'h00,0,0));
        for (int k = 0; k < 4; k++)
            vecs.push_back(mk(1,1,1,1,0,0,1,8'h55,0,1, 16'h0001,8'h00,0,0));
        vecs.push_back(mk(1,0,1,1,0,0,1,8'h55,0,1, 16'h0055,8'h02,1,0));
        vecs.push_back(mk(1,0,0,0,1,1,1,8'h00,1,1, 16'h0002,8'h00,1,0));
        // Reset mid-operation overrides stall and all strobes
        vecs.push_back(mk(0,1,1,1,0,1,0,8'hAB,1,1, 16'h0000,8'h00,0,0));
        vecs.push_back(mk(1,0,0,0,1,1,1,8'h00,1,1, 16'h0000,8'h00,0,0));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i]);
            @(posedge clk);
            #1;
            chk($sformatf("row%0d addr", i),  pu_if.addr,                vecs[i].e_addr);
            chk($sformatf("row%0d alu_b", i), {8'h00, pu_if.alu_b},      {8'h00, vecs[i].e_alu});
            chk($sformatf("row%0d sel", i),   {15'h0, pu_if.p_selector}, {15'h0, vecs[i].e_sel});
            chk($sformatf("row%0d wrap", i),  {15'h0, pu_if.ip_wrap},    {15'h0, vecs[i].e_wrap});
        end

        // No bypass: alu_b shows the pre-write DP until the edge
        @(negedge clk);
        drive(mk(1,0,0,0,0,0,1,8'h77,0,1, 16'h0000,8'h00,0,0));
        #1;
        chk("rbw_pre alu_b", {8'h00, pu_if.alu_b}, 16'h0000);
        @(posedge clk);
        #1;
        chk("rbw_post alu_b", {8'h00, pu_if.alu_b}, 16'h0077);

        // During a stall the combinational outputs still follow the inputs
        @(negedge clk);
        drive(mk(1,1,1,1,1,0,0,8'hEE,1,1, 16'h0000,8'h00,0,0));
        #1;
        chk("stall addr_dp", pu_if.addr, 16'h0077);
        pu_if.addr_dp     = 1'b0;
        pu_if.n_oe_pl_alu = 1'b0;
        #1;
        chk("stall addr_ip", pu_if.addr, 16'h0000);
        chk("stall alu_b", {8'h00, pu_if.alu_b}, 16'h0077);
        @(posedge clk);
        #1;
        chk("stall hold dp", {8'h00, pu_if.alu_b}, 16'h0077);
        chk("stall hold sel", {15'h0, pu_if.p_selector}, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
